// File: rtl/bash_pkg.sv
// Shared types and constants for the bash command stage: FSM states,
// ASCII codes, the "echo" keyword and default buffer sizes.
package bash_pkg;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    RX_CAP,
    RX_WAIT,
    DECODE,
    TX,
    SOLVE,
    ACK
  } state_t;

  localparam logic [7:0] ASCII_NUL   = 8'h00;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  // First keyword character sits in the most significant byte.
  localparam int                      KW_ECHO_LEN = 4;
  localparam logic [8*KW_ECHO_LEN-1:0] KW_ECHO    = "echo";

  localparam int MAX_LEN_DEF       = 32;
  localparam int RESP_MAX_DEF      = 40;
  localparam int SOLVE_TIMEOUT_DEF = 1023;

endpackage

// File: rtl/bash_cmd_exec_if.sv
// Character handshake between the bash terminal (master) and the command
// stage (slave): command line in, response line out, solved handshake.
interface bash_cmd_exec_if;

  logic       out_newASCII_ready;
  logic [5:0] out_lineLen;
  logic [7:0] lineOut;
  logic       lineOut_nextASCII;
  logic       in_newASCII_ready;
  logic [7:0] lineIn;
  logic       lineIn_nextASCII;
  logic       in_solved;
  logic       out_solved;

  modport master (
    output out_newASCII_ready, out_lineLen, lineOut, lineIn_nextASCII, out_solved,
    input  lineOut_nextASCII, in_newASCII_ready, lineIn, in_solved
  );

  modport slave (
    input  out_newASCII_ready, out_lineLen, lineOut, lineIn_nextASCII, out_solved,
    output lineOut_nextASCII, in_newASCII_ready, lineIn, in_solved
  );

endinterface

// File: rtl/bash_cmd_match.sv
// Combinational keyword matcher: flags "<kw> ..." (match) and "<kw>" alone
// (exact), and reports where the argument payload starts.
module bash_cmd_match
  import bash_pkg::*;
#(
  parameter int                 MAX_LEN = MAX_LEN_DEF,
  parameter int                 KW_LEN  = KW_ECHO_LEN,
  parameter logic [8*KW_LEN-1:0] KW     = KW_ECHO
) (
  input  logic [7:0] cmd_buf [MAX_LEN],
  input  logic [5:0] len,
  output logic       match,
  output logic       exact,
  output logic [5:0] offset
);

  logic prefix_eq;

  always_comb begin
    prefix_eq = 1'b1;
    for (int k = 0; k < KW_LEN; k++) begin
      if (cmd_buf[k] != KW[(KW_LEN-1-k)*8 +: 8]) prefix_eq = 1'b0;
    end
    exact  = prefix_eq && (len == 6'(KW_LEN));
    match  = prefix_eq && (len > 6'(KW_LEN)) && (cmd_buf[KW_LEN] == ASCII_SPACE);
    offset = 6'(KW_LEN + 1);
  end

endmodule

// File: rtl/bash_cmd_exec.sv
// Command stage behind the bash terminal: drains one command line, answers
// "echo" or "?: <line>", then runs the solved handshake. CMD_UPCASE_EN upcases echo payload.
module bash_cmd_exec
  import bash_pkg::*;
#(
  parameter int MAX_LEN       = MAX_LEN_DEF,
  parameter int RESP_MAX      = RESP_MAX_DEF,
  parameter int SOLVE_TIMEOUT = SOLVE_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  bash_cmd_exec_if.slave   term,
  output logic             busy,
  output logic             err_timeout
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int RW = $clog2(RESP_MAX);

  state_t          state, state_n;
  logic [5:0]      len, idx, src, kw_off, len_clamped;
  logic [RW-1:0]   ridx;
  logic [9:0]      timer;
  logic [7:0]      cmd_buf [MAX_LEN];
  logic [7:0]      resp    [RESP_MAX];
  logic [7:0]      resp_n  [RESP_MAX];
  logic            kw_match, kw_exact, char_adv, tmo;

  function automatic logic [7:0] echo_char(input logic [7:0] c);
`ifdef CMD_UPCASE_EN
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
`else
    return c;
`endif
  endfunction

  bash_cmd_match #(
    .MAX_LEN (MAX_LEN),
    .KW_LEN  (KW_ECHO_LEN),
    .KW      (KW_ECHO)
  ) u_echo (
    .cmd_buf (cmd_buf),
    .len     (len),
    .match   (kw_match),
    .exact   (kw_exact),
    .offset  (kw_off)
  );

  assign len_clamped = (term.out_lineLen > 6'(MAX_LEN)) ? 6'(MAX_LEN) : term.out_lineLen;

  // Response image; untouched entries stay NUL and terminate the line.
  always_comb begin
    src = '0;
    for (int j = 0; j < RESP_MAX; j++) resp_n[j] = ASCII_NUL;
    if (kw_match) begin
      for (int j = 0; j < MAX_LEN; j++) begin
        src = 6'(j) + kw_off;
        if (src < len) resp_n[j] = echo_char(cmd_buf[src[IW-1:0]]);
      end
    end else if (!kw_exact) begin
      resp_n[0] = ASCII_QMARK;
      resp_n[1] = ASCII_COLON;
      resp_n[2] = ASCII_SPACE;
      for (int j = 0; j < MAX_LEN; j++) begin
        if (6'(j) < len) resp_n[j+3] = cmd_buf[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SYNC;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    char_adv = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      SYNC:    if (!term.out_newASCII_ready) state_n = IDLE;
      IDLE:    if (term.out_newASCII_ready) state_n = RX_CAP;
      RX_CAP: begin
        if (!term.out_newASCII_ready) state_n = IDLE;
        else if (idx < len) begin
          char_adv = 1'b1;
          state_n  = RX_WAIT;
        end else state_n = DECODE;
      end
      RX_WAIT: state_n = term.out_newASCII_ready ? RX_CAP : IDLE;
      DECODE:  state_n = (len == 6'd0) ? SOLVE : TX;
      TX:      if (term.lineIn_nextASCII && resp[ridx] == ASCII_NUL) state_n = SOLVE;
      SOLVE:   state_n = ACK;
      ACK: begin
        if (term.out_solved) state_n = IDLE;
        else if (timer == 10'(SOLVE_TIMEOUT)) begin
          tmo     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = SYNC;
    endcase
  end

  // SYNC is the reset holding state, so busy stays low there as well as in IDLE.
  assign busy                   = (state != IDLE) && (state != SYNC);
  assign err_timeout            = tmo;
  assign term.lineOut_nextASCII = char_adv;
  assign term.in_newASCII_ready = (state == TX);
  assign term.lineIn            = (state == TX) ? resp[ridx] : ASCII_NUL;
  assign term.in_solved         = (state == SOLVE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len   <= '0;
      idx   <= '0;
      ridx  <= '0;
      timer <= '0;
      for (int k = 0; k < MAX_LEN; k++)  cmd_buf[k] <= ASCII_NUL;
      for (int k = 0; k < RESP_MAX; k++) resp[k]    <= ASCII_NUL;
    end else begin
      unique case (state)
        IDLE: if (term.out_newASCII_ready) begin
          len <= len_clamped;
          idx <= '0;
        end
        RX_CAP: if (char_adv) begin
          cmd_buf[idx[IW-1:0]] <= term.lineOut;
          idx                  <= idx + 6'd1;
        end
        DECODE: begin
          for (int k = 0; k < RESP_MAX; k++) resp[k] <= resp_n[k];
          ridx <= '0;
        end
        TX:    if (term.lineIn_nextASCII && resp[ridx] != ASCII_NUL) ridx <= ridx + RW'(1);
        SOLVE: timer <= '0;
        ACK:   timer <= timer + 10'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bash_cmd_exec.sv
// Scoreboard bench for bash_cmd_exec: stimulus pushes expected response
// bytes, a negedge monitor consumes the response line and compares.
module tb_bash_cmd_exec;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, err_timeout;

  bash_cmd_exec_if bus ();

  bash_cmd_exec dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .term        (bus),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int solved_cnt = 0, n_pulse = 0, err_cnt = 0;
  int sol_cyc = 0, err_cyc = 0, prev_pulse = 0;
  bit have_prev = 1'b0;
  bit cool = 1'b0;
  byte exp_q[$];

  logic [7:0] t_chars [64];
  int t_len = 0;
  int t_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Terminal command side: advance to the next char after each pulse.
  always @(posedge clk) begin
    if (!bus.out_newASCII_ready) t_idx <= 0;
    else if (bus.lineOut_nextASCII) t_idx <= t_idx + 1;
  end
  assign bus.lineOut = (t_idx < t_len) ? t_chars[t_idx] : 8'h00;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: consumes response chars every other cycle and tracks pulses.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      bus.lineIn_nextASCII = 1'b0;
      cool = 1'b0;
    end else if (cool) begin
      bus.lineIn_nextASCII = 1'b0;
      cool = 1'b0;
    end else if (bus.in_newASCII_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_char: got 0x%02h, expected no response", bus.lineIn);
      end else begin
        check("lineIn", int'(bus.lineIn), int'(exp_q.pop_front()));
      end
      bus.lineIn_nextASCII = 1'b1;
      cool = 1'b1;
    end
    if (bus.lineOut_nextASCII) begin
      n_pulse++;
      if (have_prev) check("pulse_spacing", cyc - prev_pulse, 2);
      prev_pulse = cyc;
      have_prev  = 1'b1;
    end
    if (!bus.out_newASCII_ready) have_prev = 1'b0;
    if (bus.in_solved) begin
      solved_cnt++;
      sol_cyc = cyc;
    end
    if (err_timeout) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h00);
  endtask

  task automatic load_cmd(input string s);
    t_len = s.len();
    for (int i = 0; i < s.len(); i++) t_chars[i] = s[i];
  endtask

  // Presents one command, waits for in_solved, optionally acknowledges.
  task automatic run_cmd(input string name, input string s, input int exp_pulses, input bit ack);
    int base_sol, base_pulse, guard;
    load_cmd(s);
    @(negedge clk);
    base_sol   = solved_cnt;
    base_pulse = n_pulse;
    bus.out_lineLen        = 6'(s.len());
    bus.out_newASCII_ready = 1'b1;
    guard = 0;
    while (solved_cnt == base_sol && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    bus.out_newASCII_ready = 1'b0;
    @(negedge clk);
    check({name, "_solved"}, solved_cnt - base_sol, 1);
    check({name, "_pulses"}, n_pulse - base_pulse, exp_pulses);
    check({name, "_resp_left"}, exp_q.size(), 0);
    if (ack) begin
      bus.out_solved = 1'b1;
      @(negedge clk);
      bus.out_solved = 1'b0;
      @(negedge clk);
      check({name, "_busy_done"}, int'(busy), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_err, base_sol, base_pulse, guard, start_cyc;
    rst_n = 1'b0;
    bus.out_newASCII_ready = 1'b0;
    bus.out_lineLen = 6'd0;
    bus.out_solved  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({bus.lineOut_nextASCII, bus.in_newASCII_ready, bus.lineIn,
                                 bus.in_solved, busy, err_timeout}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    push_str("hi");
    run_cmd("echo_hi", "echo hi", 7, 1'b1);

    load_cmd("");
    @(negedge clk);
    start_cyc = cyc;
    base_sol  = solved_cnt;
    bus.out_lineLen = 6'd0;
    bus.out_newASCII_ready = 1'b1;
    guard = 0;
    while (solved_cnt == base_sol && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.out_newASCII_ready = 1'b0;
    check("empty_solved", solved_cnt - base_sol, 1);
    check("empty_latency", sol_cyc - start_cyc, 3);
    @(negedge clk);
    bus.out_solved = 1'b1;
    @(negedge clk);
    bus.out_solved = 1'b0;
    @(negedge clk);
    check("empty_busy_done", int'(busy), 0);

    push_str("?: ls");
    run_cmd("ls", "ls", 2, 1'b1);

`ifdef CMD_UPCASE_EN
    push_str("AZ1");
`else
    push_str("aZ1");
`endif
    run_cmd("echo_aZ1", "echo aZ1", 8, 1'b1);

    push_str("");
    run_cmd("echo_exact", "echo", 4, 1'b1);

    push_str("");
    run_cmd("echo_space", "echo ", 5, 1'b1);

    push_str("?: Echo x");
    run_cmd("case_sens", "Echo x", 6, 1'b1);

    push_str("?: abcdefghijklmnopqrstuvwxyz012345");
    run_cmd("clamp", "abcdefghijklmnopqrstuvwxyz0123456789ABCD", 32, 1'b1);

    // Ready withdrawn mid-line: abort with no response and no solved pulse.
    load_cmd("echo abcdef");
    @(negedge clk);
    base_sol   = solved_cnt;
    base_pulse = n_pulse;
    bus.out_lineLen = 6'd11;
    bus.out_newASCII_ready = 1'b1;
    guard = 0;
    while (n_pulse - base_pulse < 2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.out_newASCII_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_no_solved", solved_cnt - base_sol, 0);

    push_str("?: ls");
    run_cmd("timeout", "ls", 2, 1'b0);
    base_err = err_cnt;
    guard = 0;
    while (err_cnt == base_err && guard < 1100) begin
      @(negedge clk);
      guard++;
    end
    check("timeout_fired", err_cnt - base_err, 1);
    check("timeout_delay", err_cyc - sol_cyc, 1024);
    @(negedge clk);
    check("timeout_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    check("timeout_width", err_cnt - base_err, 1);

    // Acknowledge lands in the very cycle the timer expires.
    push_str("?: ls");
    run_cmd("race", "ls", 2, 1'b0);
    base_err = err_cnt;
    while (cyc < sol_cyc + 1024) begin
      @(posedge clk);
      #1;
    end
    bus.out_solved = 1'b1;
    @(posedge clk);
    #1 bus.out_solved = 1'b0;
    repeat (3) @(negedge clk);
    check("race_no_err", err_cnt - base_err, 0);
    check("race_busy", int'(busy), 0);

    // Reset in the middle of a line with ready held high.
    load_cmd("echo hello");
    @(negedge clk);
    base_pulse = n_pulse;
    bus.out_lineLen = 6'd10;
    bus.out_newASCII_ready = 1'b1;
    guard = 0;
    while (n_pulse - base_pulse < 3 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_outputs", int'({bus.lineOut_nextASCII, bus.in_newASCII_ready, bus.lineIn,
                                  bus.in_solved, busy, err_timeout}), 0);
    rst_n = 1'b1;
    base_pulse = n_pulse;
    repeat (5) @(negedge clk);
    check("midrst_no_pulses", n_pulse - base_pulse, 0);
    check("midrst_busy", int'(busy), 0);
    bus.out_newASCII_ready = 1'b0;
    repeat (2) @(negedge clk);
    push_str("?: ls");
    run_cmd("after_rst", "ls", 2, 1'b1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
